// File: rtl/seq_frac_divider.sv
// Iterative restoring fractional divider: quot = x*2^(DEN_W-NUM_W)*2^(Q_W-1) / y, BITS_PER_CYCLE bits/clock.
// Optional round-to-nearest on the normal path: define SEQ_FRAC_DIVIDER_ROUND_EN.
module seq_frac_divider #(
  parameter int NUM_W          = 8,
  parameter int DEN_W          = 32,
  parameter int Q_W            = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NUM_W-1:0] x,
  input  logic [DEN_W-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Q_W-1:0]   quot,
  output logic [DEN_W-1:0] rem,
  output logic             div_zero,
  output logic             ovf
);

  localparam int NSTEP = Q_W / BITS_PER_CYCLE;
  localparam int CNT_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [DEN_W-1:0]   y_q, y_d;
  logic [DEN_W:0]     r_q, r_d;
  logic [Q_W-1:0]     quot_q, quot_d;
  logic [DEN_W-1:0]   rem_q, rem_d;
  logic               dz_q, dz_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [DEN_W:0]     r_step;
  logic [Q_W-1:0]     q_step;
  logic [DEN_W-1:0]   xh;

  assign xh = DEN_W'(x) << (DEN_W - NUM_W);

  // One clock's worth of restoring steps; r < 2y holds throughout, so r-y fits DEN_W bits.
  always_comb begin
    r_step = r_q;
    q_step = quot_q;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (r_step >= {1'b0, y_q}) begin
        r_step = {1'b0, r_step[DEN_W-1:0] - y_q};
        q_step = {q_step[Q_W-2:0], 1'b1};
      end else begin
        q_step = {q_step[Q_W-2:0], 1'b0};
      end
      r_step = {r_step[DEN_W-1:0], 1'b0};
    end
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    r_d     = r_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          y_d   = y;
          cnt_d = '0;
          if (y == '0) begin
            dz_d    = 1'b1;
            ovf_d   = 1'b0;
            quot_d  = '1;
            rem_d   = '0;
            state_d = DONE;
          end else if ({1'b0, xh} >= {y, 1'b0}) begin
            dz_d    = 1'b0;
            ovf_d   = 1'b1;
            quot_d  = '1;
            rem_d   = '0;
            state_d = DONE;
          end else begin
            r_d     = {1'b0, xh};
            quot_d  = '0;
            rem_d   = '0;
            dz_d    = 1'b0;
            ovf_d   = 1'b0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        r_d    = r_step;
        quot_d = q_step;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NSTEP - 1)) begin
          // After the final shift r holds 2*rem, so the rounding guard compares r directly with y.
          rem_d   = r_step[DEN_W:1];
          cnt_d   = '0;
          state_d = DONE;
`ifdef SEQ_FRAC_DIVIDER_ROUND_EN
          if ((r_step >= {1'b0, y_q}) && !(&q_step))
            quot_d = q_step + Q_W'(1);
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      y_q     <= '0;
      r_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      r_q     <= r_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quot      = quot_q;
  assign rem       = rem_q;
  assign div_zero  = dz_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_frac_divider.sv
// Directed bench for seq_frac_divider: default build (1 bit/clock) plus a 4 bits/clock instance.
module tb_seq_frac_divider;

  logic        clk, rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, div_zero, ovf;
  logic [7:0]  x, quot;
  logic [31:0] y, rem;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_div_zero, b_ovf;
  logic [7:0]  b_x, b_quot;
  logic [31:0] b_y, b_rem;

  int checks = 0;
  int errors = 0;

`ifdef SEQ_FRAC_DIVIDER_ROUND_EN
  localparam logic [7:0] Q_THIRD = 8'h2B;
`else
  localparam logic [7:0] Q_THIRD = 8'h2A;
`endif

  seq_frac_divider #(.NUM_W(8), .DEN_W(32), .Q_W(8), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y),
    .out_valid(out_valid), .out_ready(out_ready), .quot(quot), .rem(rem),
    .div_zero(div_zero), .ovf(ovf));

  seq_frac_divider #(.NUM_W(8), .DEN_W(32), .Q_W(8), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .x(b_x), .y(b_y),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .quot(b_quot), .rem(b_rem),
    .div_zero(b_div_zero), .ovf(b_ovf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operand pair on the 1-bit/clock instance; lat counts edges from (and including) the accept edge.
  task automatic run_op(input logic [7:0] xi, input logic [31:0] yi, output int lat);
    @(negedge clk);
    x = xi; y = yi; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic release_op();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, quot, rem, div_zero, ovf} !== {1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: rdy=%b vld=%b q=%h r=%h dz=%b ovf=%b, want rdy=1 vld=0 q=00 r=0 dz=0 ovf=0",
               in_ready, out_valid, quot, rem, div_zero, ovf);
    end
    checks++;
    if ({b_in_ready, b_out_valid, b_quot, b_rem, b_div_zero, b_ovf} !== {1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_bpc4: rdy=%b vld=%b q=%h r=%h", b_in_ready, b_out_valid, b_quot, b_rem);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_normal();
    logic [7:0]  tx [4] = '{8'h40, 8'h01, 8'hFF, 8'h01};
    logic [31:0] ty [4] = '{32'h8000_0000, 32'h0300_0000, 32'h8000_0000, 32'h0080_0001};
    logic [7:0]  eq [4] = '{8'h40, Q_THIRD, 8'hFF, 8'hFF};
    logic [31:0] er [4] = '{32'h0, 32'h0200_0000, 32'h0, 32'h007F_FF01};
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(tx[i], ty[i], lat);
      checks++;
      if (lat !== 9) begin
        errors++;
        $display("FAIL normal_latency[%0d]: got %0d edges, want 9", i, lat);
      end
      checks++;
      if ({quot, rem, div_zero, ovf} !== {eq[i], er[i], 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL normal_result[%0d]: q=%h r=%h dz=%b ovf=%b, want q=%h r=%h dz=0 ovf=0",
                 i, quot, rem, div_zero, ovf, eq[i], er[i]);
      end
      release_op();
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
        errors++;
        $display("FAIL normal_release[%0d]: vld=%b rdy=%b, want vld=0 rdy=1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0]  tx [2] = '{8'hFF, 8'h01};
    logic [31:0] ty [2] = '{32'h0000_0001, 32'h0080_0000};
    int lat;
    for (int i = 0; i < 2; i++) begin
      run_op(tx[i], ty[i], lat);
      checks++;
      if (lat !== 1) begin
        errors++;
        $display("FAIL ovf_latency[%0d]: got %0d edges, want 1", i, lat);
      end
      checks++;
      if ({quot, rem, div_zero, ovf} !== {8'hFF, 32'h0, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL ovf_result[%0d]: q=%h r=%h dz=%b ovf=%b, want q=ff r=0 dz=0 ovf=1",
                 i, quot, rem, div_zero, ovf);
      end
      release_op();
    end
  endtask

  task automatic test_div_zero_hold();
    int lat;
    run_op(8'h80, 32'h0, lat);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL dz_latency: got %0d edges, want 1", lat);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = i[0];
      x = 8'h40; y = 32'h8000_0000;
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, quot, rem, div_zero, ovf} !== {1'b1, 1'b0, 8'hFF, 32'h0, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL dz_hold[%0d]: vld=%b rdy=%b q=%h r=%h dz=%b ovf=%b, want vld=1 rdy=0 q=ff r=0 dz=1 ovf=0",
                 i, out_valid, in_ready, quot, rem, div_zero, ovf);
      end
    end
    in_valid = 1'b0;
    release_op();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL dz_no_queue: vld=%b rdy=%b, want vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int lat, hits, first, last;
    @(negedge clk);
    b_x = 8'h01; b_y = 32'h0300_0000; b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    lat = 1;
    while (!b_out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL bpc4_latency: got %0d edges, want 3", lat);
    end
    checks++;
    if ({b_quot, b_rem, b_div_zero, b_ovf} !== {Q_THIRD, 32'h0200_0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL bpc4_result: q=%h r=%h, want q=%h r=02000000", b_quot, b_rem, Q_THIRD);
    end
    @(negedge clk);
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    hits = 0; first = -1; last = -1;
    @(negedge clk);
    b_in_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      if (b_out_valid) begin
        checks++;
        if (last >= 0 && c - last !== 4) begin
          errors++;
          $display("FAIL b2b_spacing: result at cycle %0d after %0d, want spacing 4", c, last);
        end
        checks++;
        if (b_quot !== Q_THIRD) begin
          errors++;
          $display("FAIL b2b_quot: got %h, want %h", b_quot, Q_THIRD);
        end
        if (first < 0) first = c;
        last = c;
        hits++;
      end
    end
    b_in_valid = 1'b0;
    checks++;
    if (hits !== 4 || first !== 2) begin
      errors++;
      $display("FAIL b2b_count: %0d results first at %0d, want 4 first at 2", hits, first);
    end
    @(negedge clk);
    b_out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    int lat, seen;
    @(negedge clk);
    x = 8'h01; y = 32'h0300_0000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, quot, rem, div_zero, ovf} !== {1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: rdy=%b vld=%b q=%h r=%h dz=%b ovf=%b, want rdy=1 vld=0 q=00 r=0 dz=0 ovf=0",
               in_ready, out_valid, quot, rem, div_zero, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL aborted_output: out_valid seen %0d cycles, want 0", seen);
    end
    run_op(8'h80, 32'h8000_0000, lat);
    checks++;
    if (lat !== 9 || {quot, rem, div_zero, ovf} !== {8'h80, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL post_reset_op: lat=%0d q=%h r=%h dz=%b ovf=%b, want lat=9 q=80 r=0 dz=0 ovf=0",
               lat, quot, rem, div_zero, ovf);
    end
    release_op();
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_x = '0; b_y = '0;
    test_reset();
    test_normal();
    test_overflow();
    test_div_zero_hold();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
